// File: rtl/port_uart.sv
// port_uart: memory-mapped-port UART with 8N1 framing, TX and RX FIFOs and
// toggle-handshake CPU interface.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous, active-high reset
//   cpu_out  : [7:0] tx byte, [8] TXT tx-strobe toggle, [9] RXA rx-ack toggle,
//              [10] CLR sticky-flag clear (level); other bits ignored
//   cpu_in   : [7:0] rx byte, [8] TXK tx-ack toggle, [9] tx_full, [10] tx_busy,
//              [16] rx_valid, [17] rx_overrun, [18] rx_frame_err; others 0
//   rxd      : asynchronous serial input, idle high
//   txd      : serial output, idle high
module port_uart #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_out,
  output logic [31:0] cpu_in,
  input  logic        rxd,
  output logic        txd
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] LVL_FULL  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  logic clr;
  logic unused_bits;
  assign clr         = cpu_out[10];
  assign unused_bits = ^cpu_out[31:11];

  // ---------------------------------------------------------------- TX side
  logic          txt_q;
  logic          tx_req, tx_wr, tx_pop;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_level;
  state_t        tx_state, tx_next;
  logic [15:0]   tx_baud;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;
  logic          tx_full, tx_busy;

  assign tx_req  = cpu_out[8] ^ txt_q;
  assign tx_pop  = (tx_state == S_IDLE) && (tx_level != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign tx_wr   = tx_req && ((tx_level != LVL_FULL) || tx_pop);
  assign tx_tick = (tx_baud == BIT_LAST);
  assign tx_full = (tx_level == LVL_FULL);
  assign tx_busy = (tx_level != '0) || (tx_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= cpu_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txt_q    <= 1'b0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
    end else begin
      txt_q <= cpu_out[8];
      if (tx_wr)  tx_wp <= ptr_inc(tx_wp);
      if (tx_pop) tx_rp <= ptr_inc(tx_rp);
      case ({tx_wr, tx_pop})
        2'b10:   tx_level <= tx_level + CW'(1);
        2'b01:   tx_level <= tx_level - CW'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      S_IDLE:  if (tx_level != '0)            tx_next = S_START;
      S_START: if (tx_tick)                   tx_next = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_tick)                   tx_next = S_IDLE;
      default:                                tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (tx_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = tx_shift[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_state == S_IDLE) begin
      tx_baud <= '0;
      tx_bit  <= '0;
      if (tx_pop) tx_shift <= tx_mem[tx_rp];
    end else if (tx_tick) begin
      tx_baud <= '0;
      if (tx_state == S_DATA) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end else begin
      tx_baud <= tx_baud + 16'd1;
    end
  end

  // ---------------------------------------------------------------- RX side
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
  state_t        rx_state, rx_next;
  logic [15:0]   rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_half;
  logic          rx_done, rx_push, rx_ferr_set;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_level;
  logic          rx_wr, rx_pop, rx_ovr_set;
  logic          rxa_q, rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]    rx_data;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_baud == BIT_LAST);
  assign rx_half = (rx_baud == HALF_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      // Mid-start check rejects glitches shorter than half a bit.
      S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done     = (rx_state == S_STOP) && rx_tick;
    rx_push     = rx_done && rx_s2;
    rx_ferr_set = rx_done && !rx_s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      unique case (rx_state)
        S_IDLE: begin
          rx_baud <= '0;
          rx_bit  <= '0;
        end
        S_START: rx_baud <= rx_half ? '0 : rx_baud + 16'd1;
        default: begin
          if (rx_tick) begin
            rx_baud <= '0;
            if (rx_state == S_DATA) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
            end
          end else begin
            rx_baud <= rx_baud + 16'd1;
          end
        end
      endcase
    end
  end

  assign rx_pop     = !rx_valid && (rx_level != '0);
  assign rx_wr      = rx_push && ((rx_level != LVL_FULL) || rx_pop);
  assign rx_ovr_set = rx_push && !rx_wr;

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_wr)  rx_wp <= ptr_inc(rx_wp);
      if (rx_pop) rx_rp <= ptr_inc(rx_rp);
      case ({rx_wr, rx_pop})
        2'b10:   rx_level <= rx_level + CW'(1);
        2'b01:   rx_level <= rx_level - CW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // Holding register keeps the last byte after it is acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxa_q        <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rxa_q <= cpu_out[9];
      if (rx_valid && (cpu_out[9] ^ rxa_q)) begin
        rx_valid <= 1'b0;
      end else if (rx_pop) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_mem[rx_rp];
      end
      rx_overrun   <= rx_ovr_set  | (rx_overrun   & ~clr);
      rx_frame_err <= rx_ferr_set | (rx_frame_err & ~clr);
    end
  end

  assign cpu_in = {13'b0, rx_frame_err, rx_overrun, rx_valid,
                   5'b0, tx_busy, tx_full, txt_q, rx_data};

endmodule

// File: tb/tb_port_uart.sv
// tb_port_uart: self-checking bench for port_uart with CLKS_PER_BIT=4,
// FIFO_DEPTH=4.
module tb_port_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_out;
  logic [31:0] cpu_in;
  logic        rxd;
  logic        txd;

  always #5 clk = ~clk;

  port_uart #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_out (cpu_out),
    .cpu_in  (cpu_in),
    .rxd     (rxd),
    .txd     (txd)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] out;
    logic [31:0] exp_in;
    logic        exp_txd;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] txk_bit();
    return {23'b0, cpu_out[8], 8'b0};
  endfunction

  task automatic decode_tx(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    b  = '0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n < 400);
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (2) @(negedge clk);
    if (txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = txd;
    end
    repeat (4) @(negedge clk);
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (cpu_in[16] !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check({name, "_timeout"}, {31'b0, cpu_in[16]}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic       frame_bits [10];
    logic [7:0] tx_exp [5];
    logic [7:0] tx_got [5];
    logic       tx_ok  [5];
    logic [7:0] b;
    logic       ok;
    int         lows;

    frame_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tx_exp     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    vecs[0] = '{name: "reset",        rst: 1'b1, out: 32'h0000_0100, exp_in: 32'h0000_0000, exp_txd: 1'b1};
    vecs[1] = '{name: "reset_junk",   rst: 1'b1, out: 32'hFFFF_FFFF, exp_in: 32'h0000_0000, exp_txd: 1'b1};
    vecs[2] = '{name: "first_toggle", rst: 1'b0, out: 32'hABCD_E1A5, exp_in: 32'h0000_0500, exp_txd: 1'b1};
    vecs[3] = '{name: "start_bit",    rst: 1'b0, out: 32'hABCD_E1A5, exp_in: 32'h0000_0500, exp_txd: 1'b0};

    rst     = 1'b1;
    cpu_out = '0;
    rxd     = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      rst     = vecs[i].rst;
      cpu_out = vecs[i].out;
      cyc();
      check(vecs[i].name, cpu_in, vecs[i].exp_in);
      check({vecs[i].name, "_txd"}, {31'b0, txd}, {31'b0, vecs[i].exp_txd});
    end

    // 0xA5 frame, first start cycle already seen
    for (int k = 1; k < 40; k++) begin
      cyc();
      check($sformatf("tx_a5_c%0d", k), {31'b0, txd}, {31'b0, frame_bits[k/4]});
    end
    cyc();
    check("tx_busy_fall", cpu_in, 32'h0000_0100);

    // five back-to-back pushes, then a dropped sixth
    fork
      begin
        for (int i = 0; i < 5; i++) decode_tx(tx_got[i], tx_ok[i]);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          cpu_out[8]   = ~cpu_out[8];
          cpu_out[7:0] = tx_exp[i];
          cyc();
        end
        check("tx_full_after5", {29'b0, cpu_in[10:8]}, {29'b0, 2'b11, cpu_out[8]});
        cpu_out[8]   = ~cpu_out[8];
        cpu_out[7:0] = 8'hEE;
        cyc();
        check("txk_on_drop", {29'b0, cpu_in[10:8]}, {29'b0, 2'b11, cpu_out[8]});
      end
    join
    for (int i = 0; i < 5; i++)
      check($sformatf("tx_byte%0d", i), {23'b0, tx_ok[i], tx_got[i]}, {23'b0, 1'b1, tx_exp[i]});
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (txd !== 1'b1) lows++;
    end
    check("no_dropped_frame", 32'(lows), 32'd0);
    check("tx_idle_after5", {29'b0, cpu_in[10:8]}, {29'b0, 2'b00, cpu_out[8]});

    // RX single byte and ack
    send_rx(8'h3C, 1'b1);
    wait_valid("rx_3c");
    check("rx_3c", cpu_in, 32'h0001_003C | txk_bit());
    cpu_out[9] = ~cpu_out[9];
    cyc();
    check("rx_3c_ack", cpu_in, 32'h0000_003C | txk_bit());

    // six bytes without ack: holding + 4 FIFO, sixth overruns
    for (int i = 1; i <= 6; i++) send_rx(8'(i), 1'b1);
    repeat (3) cyc();
    check("rx_overrun", cpu_in, 32'h0003_0001 | txk_bit());
    cpu_out[10] = 1'b1;
    cyc();
    check("rx_clr_overrun", cpu_in, 32'h0001_0001 | txk_bit());
    cpu_out[10] = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      cpu_out[9] = ~cpu_out[9];
      cyc();
      cyc();
      check($sformatf("rx_fifo_%0d", j), cpu_in, 32'h0001_0000 | 32'(j) | txk_bit());
    end
    cpu_out[9] = ~cpu_out[9];
    cyc();
    cyc();
    check("rx_sixth_dropped", cpu_in, 32'h0000_0005 | txk_bit());

    // framing error coinciding with CLR: set wins, then clears
    send_rx(8'h5A, 1'b0);
    cpu_out[10] = 1'b1;
    cyc();
    check("rx_ferr_set_wins", cpu_in, 32'h0004_0005 | txk_bit());
    cyc();
    check("rx_ferr_cleared", cpu_in, 32'h0000_0005 | txk_bit());
    cpu_out[10] = 1'b0;

    // one-clock glitch
    rxd = 1'b0;
    cyc();
    rxd = 1'b1;
    repeat (50) cyc();
    check("rx_glitch", cpu_in, 32'h0000_0005 | txk_bit());

    // reset during TX data bit 3 of 0x35
    cpu_out[8]   = ~cpu_out[8];
    cpu_out[7:0] = 8'h35;
    cyc();
    repeat (17) cyc();
    check("tx_bit3_before_rst", {30'b0, cpu_in[10], txd}, 32'h2);
    rst     = 1'b1;
    cpu_out = '0;
    cyc();
    check("rst_mid_txd", {31'b0, txd}, 32'h1);
    check("rst_mid_cpu_in", cpu_in, 32'h0);
    rst     = 1'b0;
    cpu_out = 32'h0000_01C3;
    decode_tx(b, ok);
    check("tx_after_rst", {23'b0, ok, b}, {23'b0, 1'b1, 8'hC3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
